alu_flags_register: RTL and testbench
=====================================

Name: alu_flags_register

Overview:
- Downstream neighbour of the ALU output stage.
- Captures the five ALU flags (Overflow, Sign, Zero, CarryA, CarryL) into an architectural flags register under per-flag mask.
- Provides a small save/restore stack for interrupt and call entry, plus MainBus read/write of flags.
- Evaluates a 4-bit branch condition for the jump unit with a one-cycle registered result.

Parameters:
STACK_DEPTH, 4, number of flag-save entries (power of 2, 2..16)
PTR_W, 2, log2(STACK_DEPTH)

Ports:
AluClock  in  1  system clock, all state on rising edge
Reset_n  in  1  asynchronous active-low reset
Flags_In  in  5  {CarryL,CarryA,Zero,Sign,Overflow} from ALU output stage, bit0=Overflow
Flags_Load  in  1  capture Flags_In under Flags_Mask this cycle
Flags_Mask  in  5  per-flag write enable for Flags_Load
MainBus_In  in  8  bus data; bits[4:0] written to flags on Bus_Load
Bus_Load  in  1  write flags from MainBus_In[4:0], all five bits
Flags_Assert  in  1  drive flags onto Flags_BusOut
Flags_BusOut  out  8  {3'b000,flags} when Flags_Assert else 8'h00 (combinational)
Flags_Push  in  1  push current flags onto save stack
Flags_Pop  in  1  pop stack top into flags
Cond_Sel  in  4  condition code
Cond_Eval  in  1  request condition evaluation
Cond_True  out  1  registered condition result
Cond_Valid  out  1  one-cycle pulse, Cond_True valid
Flags_Out  out  5  current flags register
Stack_Empty  out  1  stack count == 0
Stack_Full  out  1  stack count == STACK_DEPTH
Stack_Error  out  1  sticky misuse flag
Error_Clear  in  1  clears Stack_Error

Behaviour:
- Reset (async, Reset_n=0): flags=5'b0, stack pointer=0, all stack entries=0, Cond_True=0, Cond_Valid=0, Stack_Error=0. Stack_Empty=1 and Stack_Full=0 follow from count 0.
- Flags write priority per cycle: Bus_Load > Pop > Flags_Load. Only the highest active source writes.
- Flags_Load: flags[i] <= Flags_Mask[i] ? Flags_In[i] : flags[i].
- Push: the entry stored is the flags value before this edge, so push+Flags_Load in one cycle saves the old flags and loads the new. Count increments.
- Push when full: stack and count are unchanged and Stack_Error is set. Flags_Load still applies.
- Pop when empty: flags and count are unchanged and Stack_Error is set. A lower-priority Flags_Load then applies.
- Push and Pop together: both are ignored, count is unchanged, and Stack_Error is set. Bus_Load and Flags_Load are still honoured.
- Pop overridden by Bus_Load: the stack still decrements and the popped value is discarded.
- Stack_Error: sticky. Set has priority over Error_Clear in the same cycle.
- Condition table, evaluated on flags register value at the edge (pre-update):
  - 0 always; 1 Z; 2 !Z; 3 CA; 4 !CA; 5 CL; 6 !CL; 7 S
  - 8 !S; 9 O; 10 !O; 11 S^O (signed lt); 12 !(S^O) (signed ge)
  - 13 CA&!Z (unsigned above); 14 !CA|Z; 15 never
- Cond_Eval at edge N: Cond_True is loaded and Cond_Valid=1 after edge N, for exactly one cycle. Without Cond_Eval, Cond_Valid=0 and Cond_True holds.
- Back-to-back Cond_Eval gives one result per cycle.
- Reset mid-operation clears the stack contents and any pending Cond_Valid immediately.

Optional Feature:
- Macro FLAGS_FORWARD_EN.
- Defined: when Flags_Load and Cond_Eval occur in the same cycle, the condition uses the masked-merged Flags_In value, i.e. the post-load flags, for one-cycle branch-after-compare. Bus_Load and Pop are not forwarded.
- Undefined: the condition always uses the pre-edge register value, and software needs one gap cycle.

Test Plan:
- Reset, then Flags_Load with Flags_In=5'b00100, Mask=5'b11111 -> Flags_Out=5'b00100. Cond_Eval Cond_Sel=1 next cycle -> Cond_True=1, Cond_Valid pulse 1 cycle. Cond_Sel=2 -> 0.
- Flags=5'b00000, load Flags_In=5'b11111 with Mask=5'b01010 -> Flags_Out=5'b01010. Flags_Assert=1 -> Flags_BusOut=8'h0A; Flags_Assert=0 -> 8'h00.
- Push 4 distinct values 01,02,04,08 (loading each before push). Fifth push -> Stack_Full=1, Stack_Error=1. Four pops restore 08,04,02,01 and Stack_Empty=1. Extra pop -> flags unchanged. Error_Clear -> Stack_Error=0.
- Push+Flags_Load same cycle (old=5'h03, new=5'h1C) -> Flags_Out=5'h1C; a later pop restores 5'h03. Push+Pop same cycle -> count unchanged, Stack_Error=1.
- Signed/unsigned conditions: S=1,O=0 -> Cond_Sel 11 true, 12 false. CA=1,Z=0 -> 13 true. CA=1,Z=1 -> 14 true. Cond_Sel 15 -> 0.
- Same-cycle Flags_Load Z=1 (from Z=0) with Cond_Eval Cond_Sel=1 -> Cond_True=1 with FLAGS_FORWARD_EN, 0 without. Assert Reset_n low mid-stack -> Stack_Empty=1, Flags_Out=0 asynchronously.

Source files
------------

// File: rtl/alu_flags_register.sv
// ALU flags register: masked flag capture, save/restore stack, bus access and a
// registered branch-condition evaluator. Optional macro FLAGS_FORWARD_EN forwards same-cycle loads to the condition.
module alu_flags_register #(
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned PTR_W       = 2
) (
  input  logic       AluClock,
  input  logic       Reset_n,
  input  logic [4:0] Flags_In,
  input  logic       Flags_Load,
  input  logic [4:0] Flags_Mask,
  input  logic [7:0] MainBus_In,
  input  logic       Bus_Load,
  input  logic       Flags_Assert,
  output logic [7:0] Flags_BusOut,
  input  logic       Flags_Push,
  input  logic       Flags_Pop,
  input  logic [3:0] Cond_Sel,
  input  logic       Cond_Eval,
  output logic       Cond_True,
  output logic       Cond_Valid,
  output logic [4:0] Flags_Out,
  output logic       Stack_Empty,
  output logic       Stack_Full,
  output logic       Stack_Error,
  input  logic       Error_Clear
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STACK_DEPTH);

  localparam int unsigned F_O  = 0;
  localparam int unsigned F_S  = 1;
  localparam int unsigned F_Z  = 2;
  localparam int unsigned F_CA = 3;
  localparam int unsigned F_CL = 4;

  typedef enum logic [3:0] {
    COND_ALWAYS = 4'd0,
    COND_Z      = 4'd1,
    COND_NZ     = 4'd2,
    COND_CA     = 4'd3,
    COND_NCA    = 4'd4,
    COND_CL     = 4'd5,
    COND_NCL    = 4'd6,
    COND_S      = 4'd7,
    COND_NS     = 4'd8,
    COND_O      = 4'd9,
    COND_NO     = 4'd10,
    COND_LT     = 4'd11,
    COND_GE     = 4'd12,
    COND_ABOVE  = 4'd13,
    COND_NABOVE = 4'd14,
    COND_NEVER  = 4'd15
  } cond_e;

  logic [4:0]       flags_q;
  logic [4:0]       flags_d;
  logic [4:0]       load_merged;
  logic [4:0]       cond_src;
  logic [4:0]       stack_q [STACK_DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] push_idx;
  logic [PTR_W-1:0] pop_idx;
  logic             stack_empty;
  logic             stack_full;
  logic             push_ok;
  logic             pop_ok;
  logic             misuse;
  logic             cond_hit;
  cond_e            cond_code;
  logic             bus_hi_unused;

  assign bus_hi_unused = ^MainBus_In[7:5];

  assign stack_empty = (count_q == '0);
  assign stack_full  = (count_q == FULL_CNT);
  assign push_idx    = count_q[PTR_W-1:0];
  assign pop_idx     = PTR_W'(count_q - 1'b1);

  // Simultaneous push and pop cancel each other and count as misuse.
  assign push_ok = Flags_Push & ~Flags_Pop & ~stack_full;
  assign pop_ok  = Flags_Pop & ~Flags_Push & ~stack_empty;
  assign misuse  = (Flags_Push & Flags_Pop)
                 | (Flags_Push & ~Flags_Pop & stack_full)
                 | (Flags_Pop & ~Flags_Push & stack_empty);

  assign load_merged = (flags_q & ~Flags_Mask) | (Flags_In & Flags_Mask);

  always_comb begin
    flags_d = flags_q;
    if (Bus_Load) begin
      flags_d = MainBus_In[4:0];
    end else if (pop_ok) begin
      flags_d = stack_q[pop_idx];
    end else if (Flags_Load) begin
      flags_d = load_merged;
    end
  end

  // A pop overridden by Bus_Load still consumes the stack entry.
  always_ff @(posedge AluClock or negedge Reset_n) begin
    if (!Reset_n) begin
      flags_q <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      flags_q <= flags_d;
      if (push_ok) begin
        stack_q[push_idx] <= flags_q;
        count_q           <= count_q + 1'b1;
      end else if (pop_ok) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge AluClock or negedge Reset_n) begin
    if (!Reset_n) begin
      Stack_Error <= 1'b0;
    end else if (misuse) begin
      Stack_Error <= 1'b1;
    end else if (Error_Clear) begin
      Stack_Error <= 1'b0;
    end
  end

`ifdef FLAGS_FORWARD_EN
  assign cond_src = Flags_Load ? load_merged : flags_q;
`else
  assign cond_src = flags_q;
`endif

  assign cond_code = cond_e'(Cond_Sel);

  always_comb begin
    cond_hit = 1'b0;
    case (cond_code)
      COND_ALWAYS: cond_hit = 1'b1;
      COND_Z:      cond_hit = cond_src[F_Z];
      COND_NZ:     cond_hit = ~cond_src[F_Z];
      COND_CA:     cond_hit = cond_src[F_CA];
      COND_NCA:    cond_hit = ~cond_src[F_CA];
      COND_CL:     cond_hit = cond_src[F_CL];
      COND_NCL:    cond_hit = ~cond_src[F_CL];
      COND_S:      cond_hit = cond_src[F_S];
      COND_NS:     cond_hit = ~cond_src[F_S];
      COND_O:      cond_hit = cond_src[F_O];
      COND_NO:     cond_hit = ~cond_src[F_O];
      COND_LT:     cond_hit = cond_src[F_S] ^ cond_src[F_O];
      COND_GE:     cond_hit = ~(cond_src[F_S] ^ cond_src[F_O]);
      COND_ABOVE:  cond_hit = cond_src[F_CA] & ~cond_src[F_Z];
      COND_NABOVE: cond_hit = ~cond_src[F_CA] | cond_src[F_Z];
      COND_NEVER:  cond_hit = 1'b0;
      default:     cond_hit = 1'b0;
    endcase
  end

  always_ff @(posedge AluClock or negedge Reset_n) begin
    if (!Reset_n) begin
      Cond_True  <= 1'b0;
      Cond_Valid <= 1'b0;
    end else begin
      Cond_Valid <= Cond_Eval;
      if (Cond_Eval) begin
        Cond_True <= cond_hit;
      end
    end
  end

  assign Flags_Out    = flags_q;
  assign Stack_Empty  = stack_empty;
  assign Stack_Full   = stack_full;
  assign Flags_BusOut = Flags_Assert ? {3'b000, flags_q} : 8'h00;

endmodule

// File: tb/tb_alu_flags_register.sv
// Self-checking bench for alu_flags_register: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_alu_flags_register;

  localparam int DEPTH = 4;
`ifdef FLAGS_FORWARD_EN
  localparam bit FWD_EXP = 1'b1;
`else
  localparam bit FWD_EXP = 1'b0;
`endif

  logic       AluClock = 1'b0;
  logic       Reset_n;
  logic [4:0] Flags_In;
  logic       Flags_Load;
  logic [4:0] Flags_Mask;
  logic [7:0] MainBus_In;
  logic       Bus_Load;
  logic       Flags_Assert;
  logic [7:0] Flags_BusOut;
  logic       Flags_Push;
  logic       Flags_Pop;
  logic [3:0] Cond_Sel;
  logic       Cond_Eval;
  logic       Cond_True;
  logic       Cond_Valid;
  logic [4:0] Flags_Out;
  logic       Stack_Empty;
  logic       Stack_Full;
  logic       Stack_Error;
  logic       Error_Clear;

  int errors = 0;
  int checks = 0;

  bit [4:0] m_flags;
  bit [4:0] m_stack[$];
  bit       m_err;
  bit       m_ct;
  bit       m_cv;

  always #5 AluClock = ~AluClock;

  alu_flags_register #(.STACK_DEPTH(DEPTH), .PTR_W(2)) dut (
    .AluClock(AluClock), .Reset_n(Reset_n), .Flags_In(Flags_In), .Flags_Load(Flags_Load),
    .Flags_Mask(Flags_Mask), .MainBus_In(MainBus_In), .Bus_Load(Bus_Load),
    .Flags_Assert(Flags_Assert), .Flags_BusOut(Flags_BusOut), .Flags_Push(Flags_Push),
    .Flags_Pop(Flags_Pop), .Cond_Sel(Cond_Sel), .Cond_Eval(Cond_Eval), .Cond_True(Cond_True),
    .Cond_Valid(Cond_Valid), .Flags_Out(Flags_Out), .Stack_Empty(Stack_Empty),
    .Stack_Full(Stack_Full), .Stack_Error(Stack_Error), .Error_Clear(Error_Clear)
  );

  function automatic bit cond_model(bit [3:0] sel, bit [4:0] f);
    bit o = f[0];
    bit s = f[1];
    bit z = f[2];
    bit ca = f[3];
    bit cl = f[4];
    case (sel)
      4'd0:  return 1'b1;
      4'd1:  return z;
      4'd2:  return !z;
      4'd3:  return ca;
      4'd4:  return !ca;
      4'd5:  return cl;
      4'd6:  return !cl;
      4'd7:  return s;
      4'd8:  return !s;
      4'd9:  return o;
      4'd10: return !o;
      4'd11: return s != o;
      4'd12: return s == o;
      4'd13: return ca && !z;
      4'd14: return !ca || z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = '0;
    m_stack.delete();
    m_err = 1'b0;
    m_ct  = 1'b0;
    m_cv  = 1'b0;
  endtask

  // Applies the current inputs to the model as one rising edge would.
  task automatic model_edge();
    bit [4:0] merged = (m_flags & ~Flags_Mask) | (Flags_In & Flags_Mask);
    bit [4:0] src    = m_flags;
    bit [4:0] popped = '0;
    bit       got    = 1'b0;
    bit       bad    = 1'b0;
`ifdef FLAGS_FORWARD_EN
    if (Flags_Load) src = merged;
`endif
    if (Cond_Eval) m_ct = cond_model(Cond_Sel, src);
    m_cv = Cond_Eval;
    if (Flags_Push && Flags_Pop) bad = 1'b1;
    else if (Flags_Push) begin
      if (m_stack.size() == DEPTH) bad = 1'b1;
      else m_stack.push_back(m_flags);
    end else if (Flags_Pop) begin
      if (m_stack.size() == 0) bad = 1'b1;
      else begin
        popped = m_stack.pop_back();
        got = 1'b1;
      end
    end
    if (Bus_Load) m_flags = MainBus_In[4:0];
    else if (got) m_flags = popped;
    else if (Flags_Load) m_flags = merged;
    if (bad) m_err = 1'b1;
    else if (Error_Clear) m_err = 1'b0;
  endtask

  task automatic clear_inputs();
    Flags_In = '0; Flags_Load = 0; Flags_Mask = '0; MainBus_In = '0; Bus_Load = 0;
    Flags_Assert = 0; Flags_Push = 0; Flags_Pop = 0; Cond_Sel = '0; Cond_Eval = 0;
    Error_Clear = 0;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge AluClock);
    #1;
  endtask

  function automatic logic [9:0] dut_state();
    return {Flags_Out, Stack_Empty, Stack_Full, Stack_Error, Cond_True, Cond_Valid};
  endfunction

  function automatic logic [9:0] model_state();
    return {m_flags, m_stack.size() == 0, m_stack.size() == DEPTH, m_err, m_ct, m_cv};
  endfunction

  task automatic test_reset();
    clear_inputs();
    Reset_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if (dut_state() !== 10'b00000_1_0_0_0_0) begin
      errors++; $display("FAIL reset_state: got %b exp %b", dut_state(), 10'b00000_1_0_0_0_0);
    end
    Flags_Assert = 1'b1;
    #1;
    checks++;
    if (Flags_BusOut !== 8'h00) begin
      errors++; $display("FAIL reset_busout: got %h exp 00", Flags_BusOut);
    end
    Flags_Assert = 1'b0;
    @(posedge AluClock);
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic test_load_cond();
    Flags_Load = 1; Flags_In = 5'b00100; Flags_Mask = 5'b11111;
    cycle();
    clear_inputs();
    checks++;
    if (Flags_Out !== 5'b00100) begin
      errors++; $display("FAIL load_full_mask: got %b exp 00100", Flags_Out);
    end
    Cond_Eval = 1; Cond_Sel = 4'd1;
    cycle();
    clear_inputs();
    checks++;
    if ({Cond_True, Cond_Valid} !== 2'b11) begin
      errors++; $display("FAIL cond_z_true: got %b exp 11", {Cond_True, Cond_Valid});
    end
    cycle();
    checks++;
    if ({Cond_True, Cond_Valid} !== 2'b10) begin
      errors++; $display("FAIL cond_valid_pulse: got %b exp 10", {Cond_True, Cond_Valid});
    end
    Cond_Eval = 1; Cond_Sel = 4'd2;
    cycle();
    clear_inputs();
    checks++;
    if ({Cond_True, Cond_Valid} !== 2'b01) begin
      errors++; $display("FAIL cond_nz_false: got %b exp 01", {Cond_True, Cond_Valid});
    end
  endtask

  task automatic test_mask_bus();
    Bus_Load = 1; MainBus_In = 8'hE0;
    cycle();
    clear_inputs();
    checks++;
    if (Flags_Out !== 5'b00000) begin
      errors++; $display("FAIL bus_load_zero: got %b exp 00000", Flags_Out);
    end
    Flags_Load = 1; Flags_In = 5'b11111; Flags_Mask = 5'b01010;
    cycle();
    clear_inputs();
    checks++;
    if (Flags_Out !== 5'b01010) begin
      errors++; $display("FAIL partial_mask: got %b exp 01010", Flags_Out);
    end
    Flags_Assert = 1;
    #1;
    checks++;
    if (Flags_BusOut !== 8'h0A) begin
      errors++; $display("FAIL busout_assert: got %h exp 0a", Flags_BusOut);
    end
    Flags_Assert = 0;
    #1;
    checks++;
    if (Flags_BusOut !== 8'h00) begin
      errors++; $display("FAIL busout_idle: got %h exp 00", Flags_BusOut);
    end
  endtask

  task automatic test_stack();
    bit [4:0] vals[4] = '{5'h01, 5'h02, 5'h04, 5'h08};
    for (int i = 0; i < 4; i++) begin
      Flags_Load = 1; Flags_In = vals[i]; Flags_Mask = 5'h1F;
      cycle();
      clear_inputs();
      Flags_Push = 1;
      cycle();
      clear_inputs();
    end
    checks++;
    if ({Stack_Full, Stack_Error} !== 2'b10) begin
      errors++; $display("FAIL stack_full: got %b exp 10", {Stack_Full, Stack_Error});
    end
    Flags_Push = 1;
    cycle();
    clear_inputs();
    checks++;
    if ({Stack_Full, Stack_Error, Flags_Out} !== {2'b11, 5'h08}) begin
      errors++; $display("FAIL push_overflow: got %b exp %b", {Stack_Full, Stack_Error, Flags_Out}, {2'b11, 5'h08});
    end
    for (int i = 3; i >= 0; i--) begin
      Flags_Pop = 1;
      cycle();
      clear_inputs();
      checks++;
      if (Flags_Out !== vals[i]) begin
        errors++; $display("FAIL pop_restore[%0d]: got %h exp %h", i, Flags_Out, vals[i]);
      end
    end
    checks++;
    if (Stack_Empty !== 1'b1) begin
      errors++; $display("FAIL stack_empty: got %b exp 1", Stack_Empty);
    end
    Flags_Pop = 1;
    cycle();
    clear_inputs();
    checks++;
    if ({Flags_Out, Stack_Empty, Stack_Error} !== {5'h01, 2'b11}) begin
      errors++; $display("FAIL pop_underflow: got %b exp %b", {Flags_Out, Stack_Empty, Stack_Error}, {5'h01, 2'b11});
    end
    Error_Clear = 1;
    cycle();
    clear_inputs();
    checks++;
    if (Stack_Error !== 1'b0) begin
      errors++; $display("FAIL error_clear: got %b exp 0", Stack_Error);
    end
  endtask

  task automatic test_push_load();
    Flags_Load = 1; Flags_In = 5'h03; Flags_Mask = 5'h1F;
    cycle();
    Flags_Push = 1; Flags_In = 5'h1C;
    cycle();
    clear_inputs();
    checks++;
    if ({Flags_Out, Stack_Empty} !== {5'h1C, 1'b0}) begin
      errors++; $display("FAIL push_with_load: got %b exp %b", {Flags_Out, Stack_Empty}, {5'h1C, 1'b0});
    end
    Flags_Pop = 1;
    cycle();
    clear_inputs();
    checks++;
    if ({Flags_Out, Stack_Empty} !== {5'h03, 1'b1}) begin
      errors++; $display("FAIL pop_old_value: got %b exp %b", {Flags_Out, Stack_Empty}, {5'h03, 1'b1});
    end
    Flags_Push = 1;
    cycle();
    Flags_Pop = 1; Bus_Load = 1; MainBus_In = 8'h11;
    cycle();
    clear_inputs();
    checks++;
    if ({Stack_Empty, Stack_Error, Flags_Out} !== {2'b01, 5'h11}) begin
      errors++; $display("FAIL push_pop_same: got %b exp %b", {Stack_Empty, Stack_Error, Flags_Out}, {2'b01, 5'h11});
    end
    Flags_Pop = 1; Bus_Load = 1; MainBus_In = 8'hF5; Error_Clear = 1;
    cycle();
    clear_inputs();
    checks++;
    if ({Flags_Out, Stack_Empty, Stack_Error} !== {5'h15, 2'b10}) begin
      errors++; $display("FAIL bus_over_pop: got %b exp %b", {Flags_Out, Stack_Empty, Stack_Error}, {5'h15, 2'b10});
    end
    checks++;
    if (dut_state() !== model_state()) begin
      errors++; $display("FAIL push_load_model: got %b exp %b", dut_state(), model_state());
    end
  endtask

  task automatic test_conditions();
    bit [4:0] cf[5]  = '{5'h02, 5'h02, 5'h08, 5'h0C, 5'h0C};
    bit [3:0] cs[5]  = '{4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    bit       ce[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      Bus_Load = 1; MainBus_In = {3'b000, cf[i]};
      cycle();
      clear_inputs();
      Cond_Eval = 1; Cond_Sel = cs[i];
      cycle();
      clear_inputs();
      checks++;
      if ({Cond_True, Cond_Valid} !== {ce[i], 1'b1}) begin
        errors++; $display("FAIL cond_sel_%0d: got %b exp %b", cs[i], {Cond_True, Cond_Valid}, {ce[i], 1'b1});
      end
    end
    for (int r = 0; r < 4; r++) begin
      Bus_Load = 1; MainBus_In = 8'($urandom);
      cycle();
      clear_inputs();
      for (int s = 0; s < 16; s++) begin
        Cond_Eval = 1; Cond_Sel = 4'(s);
        cycle();
        checks++;
        if (dut_state() !== model_state()) begin
          errors++; $display("FAIL cond_sweep f=%h sel=%0d: got %b exp %b", m_flags, s, dut_state(), model_state());
        end
      end
      clear_inputs();
    end
  endtask

  task automatic test_forward();
    Bus_Load = 1; MainBus_In = 8'h00;
    cycle();
    clear_inputs();
    Flags_Load = 1; Flags_In = 5'h04; Flags_Mask = 5'h04; Cond_Eval = 1; Cond_Sel = 4'd1;
    cycle();
    clear_inputs();
    checks++;
    if ({Cond_True, Cond_Valid, Flags_Out} !== {FWD_EXP, 1'b1, 5'h04}) begin
      errors++; $display("FAIL forward_z: got %b exp %b", {Cond_True, Cond_Valid, Flags_Out}, {FWD_EXP, 1'b1, 5'h04});
    end
  endtask

  task automatic test_back_to_back();
    Bus_Load = 1; MainBus_In = 8'($urandom);
    cycle();
    clear_inputs();
    for (int i = 0; i < 8; i++) begin
      Cond_Eval = 1; Cond_Sel = 4'($urandom);
      cycle();
      checks++;
      if (dut_state() !== model_state() || Cond_Valid !== 1'b1) begin
        errors++; $display("FAIL back_to_back[%0d]: got %b exp %b", i, dut_state(), model_state());
      end
    end
    clear_inputs();
    cycle();
    checks++;
    if (Cond_Valid !== 1'b0 || Cond_True !== m_ct) begin
      errors++; $display("FAIL b2b_idle: got %b%b exp %b0", Cond_True, Cond_Valid, m_ct);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Flags_In     = 5'($urandom);
      Flags_Mask   = 5'($urandom);
      Flags_Load   = ($urandom_range(1) == 0);
      MainBus_In   = 8'($urandom);
      Bus_Load     = ($urandom_range(7) == 0);
      Flags_Push   = ($urandom_range(3) == 0);
      Flags_Pop    = ($urandom_range(3) == 0);
      Cond_Sel     = 4'($urandom);
      Cond_Eval    = ($urandom_range(1) == 0);
      Error_Clear  = ($urandom_range(7) == 0);
      Flags_Assert = ($urandom_range(1) == 0);
      cycle();
      checks++;
      if (dut_state() !== model_state() ||
          Flags_BusOut !== (Flags_Assert ? {3'b000, m_flags} : 8'h00)) begin
        errors++; $display("FAIL random[%0d]: got %b/%h exp %b/%h", i, dut_state(), Flags_BusOut,
                           model_state(), Flags_Assert ? {3'b000, m_flags} : 8'h00);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    while (m_stack.size() != 0) begin
      Flags_Pop = 1;
      cycle();
    end
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      Flags_Load = 1; Flags_In = 5'($urandom_range(31, 1)); Flags_Mask = 5'h1F; Flags_Push = 1;
      cycle();
    end
    clear_inputs();
    Cond_Eval = 1; Cond_Sel = 4'd0;
    cycle();
    clear_inputs();
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({Flags_Out, Stack_Empty, Stack_Full, Cond_Valid} !== {5'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL async_reset: got %b exp %b", {Flags_Out, Stack_Empty, Stack_Full, Cond_Valid},
                         {5'h00, 1'b1, 1'b0, 1'b0});
    end
    @(posedge AluClock);
    #1;
    Reset_n = 1'b1;
    Flags_Push = 1;
    cycle();
    clear_inputs();
    Flags_Pop = 1;
    cycle();
    clear_inputs();
    checks++;
    if (dut_state() !== model_state()) begin
      errors++; $display("FAIL post_reset: got %b exp %b", dut_state(), model_state());
    end
  endtask

  initial begin
    test_reset();
    test_load_cond();
    test_mask_bus();
    test_stack();
    test_push_load();
    test_conditions();
    test_forward();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
